// File: rtl/eth_pkg.sv
// Shared Ethernet constants, FSM state type and CRC32 helpers for the RX FCS path.
// The CRC is kept MSB-first internally; bytes are bit-reversed on entry to match the LSB-first wire order.
package eth_pkg;

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
    localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;

    localparam int ETH_MIN_LEN = 64;
    localparam int ETH_MAX_LEN = 1518;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_PASS = 2'd2
    } fcs_state_e;

    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

    function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[31] ^ d[i];
            c  = {c[30:0], 1'b0};
            if (fb) begin
                c = c ^ CRC_POLY;
            end
        end
        return c;
    endfunction

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
        return crc32_d8(crc, bitrev8(b));
    endfunction

    function automatic logic [10:0] payload_len(input logic [10:0] n);
        return (n > 11'd4) ? (n - 11'd4) : 11'd0;
    endfunction

endpackage

// File: rtl/eth_fcs_delay.sv
// Four-byte delay line that holds back the trailing FCS; the oldest byte sits in the top slot.
import eth_pkg::*;

module eth_fcs_delay (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       clr_i,
    input  logic       push_i,
    input  logic [7:0] data_i,
    output logic [7:0] oldest_o,
    output logic [2:0] fill_o
);

    logic [31:0] line_q, line_d;
    logic [2:0]  fill_q, fill_d;

    // Clear together with push restarts the line holding just the new byte.
    always_comb begin
        line_d = line_q;
        fill_d = fill_q;
        if (clr_i) begin
            line_d = push_i ? {24'h0, data_i} : 32'h0;
            fill_d = push_i ? 3'd1 : 3'd0;
        end else if (push_i) begin
            line_d = {line_q[23:0], data_i};
            fill_d = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            line_q <= 32'h0;
            fill_q <= 3'd0;
        end else begin
            line_q <= line_d;
            fill_q <= fill_d;
        end
    end

    assign oldest_o = line_q[31:24];
    assign fill_o   = fill_q;

endmodule

// File: rtl/eth_fcs_checker.sv
// Receive FCS checker: runs CRC32 over the whole frame, strips the FCS through the delay line
// and reports per-frame CRC, length and abort status alongside the last payload byte.
import eth_pkg::*;

module eth_fcs_checker #(
    parameter int MIN_LEN = ETH_MIN_LEN,
    parameter int MAX_LEN = ETH_MAX_LEN
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_sof,
    input  logic        rx_eof,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_sof,
    output logic        m_eof,
    output logic        status_valid,
    output logic        crc_err,
    output logic        len_err,
    output logic        abort,
    output logic [10:0] frame_len
);

    localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L   = 11'(MAX_LEN);
    localparam logic [10:0] CNT_SAT = 11'h7FF;

    fcs_state_e  state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [10:0] cnt_q, cnt_d;
    logic        started_q, started_d;

    logic [7:0]  m_data_q, m_data_d;
    logic        m_valid_q, m_valid_d;
    logic        m_sof_q, m_sof_d;
    logic        m_eof_q, m_eof_d;
    logic        status_valid_q, status_valid_d;
    logic        crc_err_q, crc_err_d;
    logic        len_err_q, len_err_d;
    logic        abort_q, abort_d;
    logic [10:0] frame_len_q, frame_len_d;

    logic        dl_clr, dl_push;
    logic [7:0]  dl_oldest;
    logic [2:0]  dl_fill;

    logic [31:0] crc_first, crc_next;
    logic [10:0] cnt_inc;

    eth_fcs_delay u_delay (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr_i     (dl_clr),
        .push_i    (dl_push),
        .data_i    (rx_data),
        .oldest_o  (dl_oldest),
        .fill_o    (dl_fill)
    );

    function automatic logic len_bad(input logic [10:0] n);
        return (n < MIN_L) || (n > MAX_L);
    endfunction

    assign crc_first = crc32_byte(CRC_INIT, rx_data);
    assign crc_next  = crc32_byte(crc_q, rx_data);
    assign cnt_inc   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 11'd1;

    always_comb begin
        state_d        = state_q;
        crc_d          = crc_q;
        cnt_d          = cnt_q;
        started_d      = started_q;
        dl_clr         = 1'b0;
        dl_push        = 1'b0;
        m_data_d       = 8'h00;
        m_valid_d      = 1'b0;
        m_sof_d        = 1'b0;
        m_eof_d        = 1'b0;
        status_valid_d = 1'b0;
        crc_err_d      = 1'b0;
        len_err_d      = 1'b0;
        abort_d        = 1'b0;
        frame_len_d    = 11'd0;
        if (rx_valid) begin
            if (rx_sof) begin
                // A new start mid-frame closes the old frame as aborted before restarting.
                if (state_q != ST_IDLE) begin
                    status_valid_d = 1'b1;
                    abort_d        = 1'b1;
                    crc_err_d      = 1'b1;
                    len_err_d      = len_bad(cnt_q);
                    frame_len_d    = payload_len(cnt_q);
                    m_valid_d      = started_q;
                    m_eof_d        = started_q;
                end
                crc_d     = crc_first;
                cnt_d     = 11'd1;
                started_d = 1'b0;
                dl_clr    = 1'b1;
                dl_push   = 1'b1;
                state_d   = ST_FILL;
                if (rx_eof && (state_q == ST_IDLE)) begin
                    status_valid_d = 1'b1;
                    crc_err_d      = (crc_first != CRC_RESIDUE);
                    len_err_d      = len_bad(11'd1);
                    dl_push        = 1'b0;
                    state_d        = ST_IDLE;
                end
            end else if (state_q != ST_IDLE) begin
                crc_d   = crc_next;
                cnt_d   = cnt_inc;
                dl_push = 1'b1;
                if (state_q == ST_PASS) begin
                    m_valid_d = 1'b1;
                    m_data_d  = dl_oldest;
                    m_sof_d   = !started_q;
                    m_eof_d   = rx_eof;
                    started_d = 1'b1;
                end
                if (rx_eof) begin
                    status_valid_d = 1'b1;
                    crc_err_d      = (crc_next != CRC_RESIDUE);
                    len_err_d      = len_bad(cnt_inc);
                    frame_len_d    = payload_len(cnt_inc);
                    dl_clr         = 1'b1;
                    dl_push        = 1'b0;
                    started_d      = 1'b0;
                    state_d        = ST_IDLE;
                end else if (dl_fill == 3'd3) begin
                    state_d = ST_PASS;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q        <= ST_IDLE;
            crc_q          <= CRC_INIT;
            cnt_q          <= 11'd0;
            started_q      <= 1'b0;
            m_data_q       <= 8'h00;
            m_valid_q      <= 1'b0;
            m_sof_q        <= 1'b0;
            m_eof_q        <= 1'b0;
            status_valid_q <= 1'b0;
            crc_err_q      <= 1'b0;
            len_err_q      <= 1'b0;
            abort_q        <= 1'b0;
            frame_len_q    <= 11'd0;
        end else begin
            state_q        <= state_d;
            crc_q          <= crc_d;
            cnt_q          <= cnt_d;
            started_q      <= started_d;
            m_data_q       <= m_data_d;
            m_valid_q      <= m_valid_d;
            m_sof_q        <= m_sof_d;
            m_eof_q        <= m_eof_d;
            status_valid_q <= status_valid_d;
            crc_err_q      <= crc_err_d;
            len_err_q      <= len_err_d;
            abort_q        <= abort_d;
            frame_len_q    <= frame_len_d;
        end
    end

    assign m_data       = m_data_q;
    assign m_valid      = m_valid_q;
    assign m_sof        = m_sof_q;
    assign m_eof        = m_eof_q;
    assign status_valid = status_valid_q;
    assign crc_err      = crc_err_q;
    assign len_err      = len_err_q;
    assign abort        = abort_q;
    assign frame_len    = frame_len_q;

endmodule

// File: doc/eth_fcs_checker.md
# eth_fcs_checker

Receive-side FCS checker for the Ethernet RX path, the counterpart of the TX CRC32 generator that appends the FCS. It takes the de-preambled byte stream from the RMII receive deserializer, runs the same CRC32 (init all-ones, reflected bytes) over every byte including the FCS, and strips the 4 FCS bytes through a delay line. It emits per-frame status (CRC error, length error, abort) so the UDP/IP parser can discard bad frames.

## Interface
- `MIN_LEN`, 64: minimum frame length in bytes, FCS included.
- `MAX_LEN`, 1518: maximum frame length in bytes, FCS included.
- `sys_clk` input 1: single clock, all logic on rising edge.
- `sys_rst_n` input 1: reset is synchronous and active-low.
- `rx_data` input 8: received byte.
- `rx_valid` input 1: byte strobe. `rx_sof` and `rx_eof` are ignored when this is low.
- `rx_sof` input 1: first byte of frame.
- `rx_eof` input 1: last byte of frame, which is the last FCS byte.
- `m_data` output 8: payload byte, FCS removed.
- `m_valid` output 1: `m_data` valid.
- `m_sof` output 1: first payload byte.
- `m_eof` output 1: last payload byte.
- `status_valid` output 1: one-cycle pulse carrying the frame status.
- `crc_err` output 1: the CRC residue check failed.
- `len_err` output 1: frame length is below `MIN_LEN` or above `MAX_LEN`.
- `abort` output 1: frame was ended by a new `rx_sof` instead of `rx_eof`.
- `frame_len` output 11: payload length in bytes (frame length minus 4, floored at 0).

## Operation
- States:
  - IDLE: waiting for a frame.
  - FILL: fewer than 4 bytes buffered.
  - PASS: 4 bytes buffered.
- IDLE, accepted byte with `rx_sof`:
  - CRC register = next(FFFF_FFFF, byte), byte count = 1, byte stored in delay line slot 0, go to FILL.
  - Accepted bytes without `rx_sof` in IDLE are dropped.
- FILL/PASS, accepted byte: CRC register = next(crc, byte); count +1, saturating at 2047; byte shifted into the 4-deep delay line.
- FILL moves to PASS when the 4th byte is accepted.
- In PASS, each accepted byte pushes the oldest buffered byte out on `m_data`:
  - `m_sof` is set on the first byte pushed out.
  - `m_eof` is set when the pushing input byte carries `rx_eof`.
- Accepted byte with `rx_eof` (allowed in FILL or PASS) ends the frame. Status is pulsed, the delay line is cleared, go to IDLE.
- CRC check: `crc_err` = (CRC register after the last byte != 32'hC704_DD7B). This is the residue in the internal MSB-first form, i.e. before bit-reversal and complement.
- `len_err` = (count < `MIN_LEN`) or (count > `MAX_LEN`). A saturated count always gives `len_err`.
- Frames of 4 bytes or fewer produce no `m_*` bytes, only a status pulse with `len_err` = 1.
- Single-byte frame (`rx_sof` and `rx_eof` on the same byte): status with `len_err` = 1, `frame_len` = 0.
- Accepted `rx_sof` while in FILL/PASS (abort):
  - Status is pulsed for the old frame with `abort` = 1, `crc_err` = 1, and `len_err` evaluated on the old count.
  - If at least one old payload byte was already output, `m_valid`/`m_eof` are asserted with `m_data` = 0 in the same cycle as the status pulse, so the downstream frame closes.
  - The buffered old bytes are discarded. The new byte restarts the frame in FILL.
- `rx_valid` = 0 mid-frame: no state change and no output that cycle. Gaps are unlimited.

## Timing
- Every `m_*` and status output is registered: it appears exactly 1 cycle after the accepting input edge.
- `m_eof` and `status_valid` are asserted in the same cycle.
- Back-to-back frames: an `rx_sof` byte the cycle after an `rx_eof` byte is accepted with no bubble.
- Output duty follows the input: at most one `m_valid` per accepted byte, no backpressure.
- Reset value of every output is 0. On reset the CRC register goes to FFFF_FFFF, count to 0, state to IDLE, and the delay line is cleared.
- Reset mid-frame discards the frame silently: no status pulse, no `m_eof`.

## Structure
- Shared package `eth_pkg` holds:
  - the CRC32 D8 next-state function, with the byte bit-reversal wrapper;
  - `CRC_INIT` = 32'hFFFF_FFFF and `CRC_RESIDUE` = 32'hC704_DD7B;
  - default length constants;
  - the state enum.
- One natural sub-module, `eth_fcs_delay`: a 4-byte shift register with fill count and clear. The checker top holds the FSM, CRC, length counter and status logic.

## Test plan
- `MIN_LEN` = 5. Frame "123456789" (31..39) followed by FCS 26 39 F4 CB (CRC32 = CBF4_3926) -> 9 payload bytes out, `m_sof` on 31, `m_eof` on 39; status `crc_err` = 0, `len_err` = 0, `frame_len` = 9.
- Same frame with FCS byte CB changed to CA -> identical payload; `crc_err` = 1, `frame_len` = 9.
- Defaults. 63-byte frame with correct FCS -> `len_err` = 1, `crc_err` = 0, `frame_len` = 59. Then a 64-byte frame -> `len_err` = 0.
- Two back-to-back good frames with random `rx_valid` gaps of 0–3 cycles -> payload is byte-exact, exactly two status pulses, both clean.
- `rx_sof` at byte 20 of a frame -> `abort` = 1, `crc_err` = 1, forced `m_eof` with `m_data` = 00. The following frame is checked normally.
- `sys_rst_n` low for 1 cycle at byte 30 -> all outputs 0 next cycle, no status for that frame. The next frame passes.
